pkt_rate_meter: RTL

Inline AXI-Stream throughput meter placed directly downstream of the packet queue's master port. Passes every beat through a 2-entry registered skid buffer with no modification. Counts packets and payload bytes accepted on its slave port over a fixed window of clock cycles. Publishes a one-cycle snapshot per window for the flow-speed statistics logic.

---
 rtl/pkt_rate_meter.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_rate_meter.sv
// -----------------------------------------------------------------------------
// pkt_rate_meter
//
// Inline AXI-Stream throughput meter. Every beat passes unchanged through a
// 2-entry registered skid buffer. Packets and payload bytes accepted on the
// slave port are accumulated over a fixed window of aclk cycles, and a
// one-cycle snapshot is published when each window closes.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             input beat stream (tvalid/tdata/tlast/tuser_mty, tready out)
//   m_axis_*             registered output beat stream (tready in)
//   meter_restart        pulse: restart the window and clear the accumulators
//   stat_valid           one-cycle pulse at each window close
//   stat_pkts/bytes      packet/byte totals of the closed window (held)
//   stat_sat             a counter saturated during the closed window
//   stat_mty_err         a last beat in the closed window had mty >= bytes/beat
// -----------------------------------------------------------------------------
module pkt_rate_meter #(
    parameter int C_DATA_WIDTH    = 256,
    parameter int C_MTY_WIDTH     = 5,
    parameter int C_WINDOW_CYCLES = 156250,
    parameter int C_CNT_WIDTH     = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [C_MTY_WIDTH-1:0]  s_axis_tuser_mty,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]  m_axis_tuser_mty,
    input  logic                    m_axis_tready,
    input  logic                    meter_restart,
    output logic                    stat_valid,
    output logic [C_CNT_WIDTH-1:0]  stat_pkts,
    output logic [C_CNT_WIDTH-1:0]  stat_bytes,
    output logic                    stat_sat,
    output logic                    stat_mty_err
);

    localparam int BPB   = C_DATA_WIDTH / 8;
    localparam int WC_W  = $clog2(C_WINDOW_CYCLES);
    localparam int BPB_W = $clog2(BPB + 1);
    localparam int MAX_A = (C_CNT_WIDTH > C_MTY_WIDTH) ? C_CNT_WIDTH : C_MTY_WIDTH;
    // Sum width: one bit more than any operand so an overflow past the
    // counter maximum is always visible before saturation.
    localparam int SW    = ((MAX_A > BPB_W) ? MAX_A : BPB_W) + 1;

    localparam logic [SW-1:0]          BPB_S     = SW'(BPB);
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX_C = {C_CNT_WIDTH{1'b1}};
    localparam logic [SW-1:0]          CNT_MAX_S = SW'(CNT_MAX_C);
    localparam logic [WC_W-1:0]        WC_LAST   = WC_W'(C_WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // ---------------- skid buffer registers ----------------
    skid_state_e               state_q;
    logic                      tready_q;
    logic                      m_valid_q;
    logic [C_DATA_WIDTH-1:0]   m_data_q;
    logic                      m_last_q;
    logic [C_MTY_WIDTH-1:0]    m_mty_q;
    logic [C_DATA_WIDTH-1:0]   skid_data_q;
    logic                      skid_last_q;
    logic [C_MTY_WIDTH-1:0]    skid_mty_q;

    // ---------------- meter registers ----------------
    logic [WC_W-1:0]        wc_q,          wc_d;
    logic [C_CNT_WIDTH-1:0] pkt_acc_q,     pkt_acc_d;
    logic [C_CNT_WIDTH-1:0] byte_acc_q,    byte_acc_d;
    logic                   sat_q,         sat_d;
    logic                   mty_err_q,     mty_err_d;
    logic                   stat_valid_q,  stat_valid_d;
    logic [C_CNT_WIDTH-1:0] stat_pkts_q,   stat_pkts_d;
    logic [C_CNT_WIDTH-1:0] stat_bytes_q,  stat_bytes_d;
    logic                   stat_sat_q,    stat_sat_d;
    logic                   stat_mty_err_q, stat_mty_err_d;

    // ---------------- combinational helpers ----------------
    logic                   s_acc_s;
    logic                   m_acc_s;
    logic [SW-1:0]          mty_s;
    logic                   mty_bad_s;
    logic [SW-1:0]          bytes_add_s;
    logic [SW-1:0]          pkt_add_s;
    logic [SW-1:0]          pkt_sum_s;
    logic [SW-1:0]          byte_sum_s;
    logic                   pkt_ovf_s;
    logic                   byte_ovf_s;
    logic [C_CNT_WIDTH-1:0] pkt_new_s;
    logic [C_CNT_WIDTH-1:0] byte_new_s;
    logic                   sat_new_s;
    logic                   mty_err_new_s;
    logic                   terminal_s;

    assign s_acc_s    = s_axis_tvalid && tready_q;
    assign m_acc_s    = m_valid_q && m_axis_tready;
    assign mty_s      = SW'(s_axis_tuser_mty);
    assign mty_bad_s  = s_axis_tlast && (mty_s >= BPB_S);
    assign terminal_s = (wc_q == WC_LAST);

    // Byte and packet contribution of the beat accepted this cycle
    always_comb begin
        bytes_add_s = '0;
        if (!s_acc_s) begin
            bytes_add_s = '0;
        end else if (!s_axis_tlast) begin
            bytes_add_s = BPB_S;
        end else if (mty_bad_s) begin
            bytes_add_s = '0;
        end else begin
            bytes_add_s = BPB_S - mty_s;
        end
    end

    assign pkt_add_s  = (s_acc_s && s_axis_tlast) ? SW'(1) : SW'(0);
    assign pkt_sum_s  = SW'(pkt_acc_q) + pkt_add_s;
    assign byte_sum_s = SW'(byte_acc_q) + bytes_add_s;
    assign pkt_ovf_s  = (pkt_sum_s > CNT_MAX_S);
    assign byte_ovf_s = (byte_sum_s > CNT_MAX_S);
    assign pkt_new_s  = pkt_ovf_s  ? CNT_MAX_C : pkt_sum_s[C_CNT_WIDTH-1:0];
    assign byte_new_s = byte_ovf_s ? CNT_MAX_C : byte_sum_s[C_CNT_WIDTH-1:0];
    assign sat_new_s     = sat_q || pkt_ovf_s || byte_ovf_s;
    assign mty_err_new_s = mty_err_q || (s_acc_s && mty_bad_s);

    // Next-state for the window counter, accumulators and published snapshot
    always_comb begin
        wc_d           = terminal_s ? '0 : (wc_q + WC_W'(1));
        pkt_acc_d      = pkt_new_s;
        byte_acc_d     = byte_new_s;
        sat_d          = sat_new_s;
        mty_err_d      = mty_err_new_s;
        stat_valid_d   = 1'b0;
        stat_pkts_d    = stat_pkts_q;
        stat_bytes_d   = stat_bytes_q;
        stat_sat_d     = stat_sat_q;
        stat_mty_err_d = stat_mty_err_q;
        if (meter_restart) begin
            // Restart wins over window close; this cycle's beat is dropped
            // from the count and the snapshot is left untouched.
            wc_d       = '0;
            pkt_acc_d  = '0;
            byte_acc_d = '0;
            sat_d      = 1'b0;
            mty_err_d  = 1'b0;
        end else if (terminal_s) begin
            // A beat accepted in the terminal cycle belongs to the closing window
            stat_valid_d   = 1'b1;
            stat_pkts_d    = pkt_new_s;
            stat_bytes_d   = byte_new_s;
            stat_sat_d     = sat_new_s;
            stat_mty_err_d = mty_err_new_s;
            pkt_acc_d      = '0;
            byte_acc_d     = '0;
            sat_d          = 1'b0;
            mty_err_d      = 1'b0;
        end else begin
            stat_valid_d = 1'b0;
        end
    end

    // Meter state registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wc_q           <= '0;
            pkt_acc_q      <= '0;
            byte_acc_q     <= '0;
            sat_q          <= 1'b0;
            mty_err_q      <= 1'b0;
            stat_valid_q   <= 1'b0;
            stat_pkts_q    <= '0;
            stat_bytes_q   <= '0;
            stat_sat_q     <= 1'b0;
            stat_mty_err_q <= 1'b0;
        end else begin
            wc_q           <= wc_d;
            pkt_acc_q      <= pkt_acc_d;
            byte_acc_q     <= byte_acc_d;
            sat_q          <= sat_d;
            mty_err_q      <= mty_err_d;
            stat_valid_q   <= stat_valid_d;
            stat_pkts_q    <= stat_pkts_d;
            stat_bytes_q   <= stat_bytes_d;
            stat_sat_q     <= stat_sat_d;
            stat_mty_err_q <= stat_mty_err_d;
        end
    end

    // Skid buffer FSM: head beat drives m_axis, second slot absorbs one stall
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= SKID_EMPTY;
            tready_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_mty_q     <= '0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_mty_q  <= '0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    tready_q <= 1'b1;
                    if (s_acc_s) begin
                        m_data_q  <= s_axis_tdata;
                        m_last_q  <= s_axis_tlast;
                        m_mty_q   <= s_axis_tuser_mty;
                        m_valid_q <= 1'b1;
                        state_q   <= SKID_ONE;
                    end else begin
                        m_valid_q <= 1'b0;
                        state_q   <= SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    case ({s_acc_s, m_acc_s})
                        2'b10: begin
                            skid_data_q <= s_axis_tdata;
                            skid_last_q <= s_axis_tlast;
                            skid_mty_q  <= s_axis_tuser_mty;
                            tready_q    <= 1'b0;
                            state_q     <= SKID_TWO;
                        end
                        2'b01: begin
                            m_valid_q <= 1'b0;
                            state_q   <= SKID_EMPTY;
                        end
                        2'b11: begin
                            m_data_q <= s_axis_tdata;
                            m_last_q <= s_axis_tlast;
                            m_mty_q  <= s_axis_tuser_mty;
                        end
                        default: begin
                            state_q <= SKID_ONE;
                        end
                    endcase
                end
                SKID_TWO: begin
                    if (m_acc_s) begin
                        m_data_q <= skid_data_q;
                        m_last_q <= skid_last_q;
                        m_mty_q  <= skid_mty_q;
                        tready_q <= 1'b1;
                        state_q  <= SKID_ONE;
                    end else begin
                        state_q <= SKID_TWO;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty buffer
                    m_valid_q <= 1'b0;
                    tready_q  <= 1'b1;
                    state_q   <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign s_axis_tready    = tready_q;
    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tdata     = m_data_q;
    assign m_axis_tlast     = m_last_q;
    assign m_axis_tuser_mty = m_mty_q;
    assign stat_valid       = stat_valid_q;
    assign stat_pkts        = stat_pkts_q;
    assign stat_bytes       = stat_bytes_q;
    assign stat_sat         = stat_sat_q;
    assign stat_mty_err     = stat_mty_err_q;

endmodule
